// File: rtl/mul_result_reader_if.sv
// Request/response handshake bundle between the result reader and the
// writeback/operand-fetch side.
interface mul_result_reader_if #(
  parameter int ADDRS_WIDTH = 4
) ();
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDRS_WIDTH-1:0] req_addrs;
  logic                   req_hi;
  logic                   req_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic [3:0]             out_flags;
  logic                   out_err;

  modport master (
    output req_valid, req_addrs, req_hi, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_flags, out_err
  );

  modport slave (
    input  req_valid, req_addrs, req_hi, req_last, out_ready,
    output req_ready, out_valid, out_data, out_flags, out_err
  );
endinterface

// File: rtl/mul_result_reader.sv
// Reads results from the multiplier's result buffer once their slot has been
// written, returning one 32-bit product half plus {C,V,N,Z} per request.
module mul_result_reader #(
  parameter int ADDRS_WIDTH = 4,
  parameter int WAIT_LIMIT  = 255,
  parameter int WCNT_WIDTH  = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      mul_wren,
  input  logic [ADDRS_WIDTH-1:0]    mul_wraddrs,
  mul_result_reader_if.slave        bus,
  output logic                      rdenA,
  output logic [ADDRS_WIDTH-1:0]    rdaddrsA,
  input  logic [67:0]               rddataA,
  output logic [2**ADDRS_WIDTH-1:0] slot_valid
);

  localparam int NSLOTS = 2**ADDRS_WIDTH;
  localparam logic [WCNT_WIDTH-1:0] WAIT_LAST = WCNT_WIDTH'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_CAPT = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRS_WIDTH-1:0]  addr_q, addr_d;
  logic                    hi_q, hi_d;
  logic                    last_q, last_d;
  logic [WCNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [NSLOTS-1:0]       slot_valid_q, slot_valid_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rden_q, rden_d;
  logic [ADDRS_WIDTH-1:0]  rdaddrs_q, rdaddrs_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             out_data_q, out_data_d;
  logic [3:0]              out_flags_q, out_flags_d;
  logic                    out_err_q, out_err_d;
  logic                    clr_s;

  // Next-state, registered-output and slot bitmap logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hi_d         = hi_q;
    last_d       = last_q;
    wcnt_d       = wcnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    clr_s        = 1'b0;
    slot_valid_d = slot_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addrs;
          hi_d   = bus.req_hi;
          last_d = bus.req_last;
          wcnt_d = '0;
          // Uses the registered bitmap, so a same-cycle write still waits.
          if (slot_valid_q[bus.req_addrs]) begin
            state_d = S_READ;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + WCNT_WIDTH'(1);
        if (slot_valid_q[addr_q]) begin
          state_d = S_READ;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_data_d  = 32'h0000_0000;
          out_flags_d = 4'h0;
          out_err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        out_data_d  = hi_q ? rddataA[63:32] : rddataA[31:0];
        out_flags_d = rddataA[67:64];
        out_err_d   = 1'b0;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          clr_s       = last_q & ~out_err_q;
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = 32'h0000_0000;
          out_flags_d = 4'h0;
          out_err_d   = 1'b0;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_data_d  = 32'h0000_0000;
        out_flags_d = 4'h0;
        out_err_d   = 1'b0;
      end
    endcase

    // Clear first so a simultaneous write to the same slot wins.
    if (clr_s) begin
      slot_valid_d[addr_q] = 1'b0;
    end else begin
      slot_valid_d = slot_valid_d;
    end
    if (mul_wren) begin
      slot_valid_d[mul_wraddrs] = 1'b1;
    end else begin
      slot_valid_d = slot_valid_d;
    end

    rden_d      = (state_d == S_READ);
    rdaddrs_d   = rden_d ? addr_d : rdaddrs_q;
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      hi_q         <= 1'b0;
      last_q       <= 1'b0;
      wcnt_q       <= '0;
      slot_valid_q <= '0;
      req_ready_q  <= 1'b1;
      rden_q       <= 1'b0;
      rdaddrs_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0000_0000;
      out_flags_q  <= 4'h0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hi_q         <= hi_d;
      last_q       <= last_d;
      wcnt_q       <= wcnt_d;
      slot_valid_q <= slot_valid_d;
      req_ready_q  <= req_ready_d;
      rden_q       <= rden_d;
      rdaddrs_q    <= rdaddrs_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_err   = out_err_q;
  assign rdenA         = rden_q;
  assign rdaddrsA      = rdaddrs_q;
  assign slot_valid    = slot_valid_q;

endmodule

// File: tb/tb_mul_result_reader.sv
// Directed bench for mul_result_reader: hit, hi-half, stall-then-hit,
// timeout, output backpressure and mid-operation reset.
module tb_mul_result_reader;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          mul_wren;
  logic [AW-1:0] mul_wraddrs;
  logic          rdenA;
  logic [AW-1:0] rdaddrsA;
  logic [67:0]   rddataA;
  logic [15:0]   slot_valid;
  logic [67:0]   mem [16];

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  mul_result_reader_if #(.ADDRS_WIDTH(AW)) bus ();

  mul_result_reader #(.ADDRS_WIDTH(AW), .WAIT_LIMIT(255), .WCNT_WIDTH(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .mul_wren   (mul_wren),
    .mul_wraddrs(mul_wraddrs),
    .bus        (bus),
    .rdenA      (rdenA),
    .rdaddrsA   (rdaddrsA),
    .rddataA    (rddataA),
    .slot_valid (slot_valid)
  );

  always #5 CLK = ~CLK;

  // Result buffer port A: data valid the cycle after the read enable.
  always @(posedge CLK) begin
    if (rdenA) rddataA <= mem[rdaddrsA];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [AW-1:0] a, input logic hi, input logic last);
    bus.req_valid = 1'b1;
    bus.req_addrs = a;
    bus.req_hi    = hi;
    bus.req_last  = last;
  endtask

  initial begin
    int early;
    for (int i = 0; i < 16; i++) mem[i] = 68'h0;
    mem[3] = {4'b0010, 64'hFFFFFFFF_FFFFFFFE};
    mem[9] = {4'b1001, 64'h12345678_9ABCDEF0};
    mem[5] = {4'b1111, 64'hDEADBEEF_CAFEF00D};
    rddataA = 68'h0;
    RESET = 1'b0;
    mul_wren = 1'b0;
    mul_wraddrs = '0;
    bus.req_valid = 1'b0;
    bus.req_addrs = '0;
    bus.req_hi = 1'b0;
    bus.req_last = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rden", 64'(rdenA), 64'd0);
    chk("rst_rdaddr", 64'(rdaddrsA), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_slot_valid", 64'(slot_valid), 64'd0);
    RESET = 1'b1;

    // Test 1: write slot 3, read low half with last=1
    @(negedge CLK);
    mul_wren = 1'b1; mul_wraddrs = 4'd3;
    @(negedge CLK);
    mul_wren = 1'b0;
    chk("t1_slot_set", 64'(slot_valid), 64'h0008);
    req(4'd3, 1'b0, 1'b1);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("t1_rden", 64'(rdenA), 64'd1);
    chk("t1_rdaddr", 64'(rdaddrsA), 64'd3);
    chk("t1_req_ready_busy", 64'(bus.req_ready), 64'd0);
    @(negedge CLK);
    chk("t1_rden_once", 64'(rdenA), 64'd0);
    chk("t1_rdaddr_hold", 64'(rdaddrsA), 64'd3);
    chk("t1_not_yet_valid", 64'(bus.out_valid), 64'd0);
    @(negedge CLK);
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out_data", 64'(bus.out_data), 64'hFFFFFFFE);
    chk("t1_out_flags", 64'(bus.out_flags), 64'b0010);
    chk("t1_out_err", 64'(bus.out_err), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t1_slot_freed", 64'(slot_valid), 64'h0000);
    chk("t1_out_done", 64'(bus.out_valid), 64'd0);
    chk("t1_req_ready", 64'(bus.req_ready), 64'd1);

    // Test 2: rewrite slot 3, read high half with last=0
    mul_wren = 1'b1; mul_wraddrs = 4'd3;
    @(negedge CLK);
    mul_wren = 1'b0;
    req(4'd3, 1'b1, 1'b0);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("t2_rden", 64'(rdenA), 64'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_out_data", 64'(bus.out_data), 64'hFFFFFFFF);
    chk("t2_out_flags", 64'(bus.out_flags), 64'b0010);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t2_slot_kept", 64'(slot_valid), 64'h0008);

    // Test 3: request unwritten slot 9, write it later
    req(4'd9, 1'b0, 1'b1);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("t3_wait_req_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_wait_no_rden", 64'(rdenA), 64'd0);
      @(negedge CLK);
    end
    mul_wren = 1'b1; mul_wraddrs = 4'd9;
    chk("t3_same_cycle_no_rden", 64'(rdenA), 64'd0);
    @(negedge CLK);
    mul_wren = 1'b0;
    chk("t3_slot9_set", 64'(slot_valid), 64'h0208);
    chk("t3_rden_not_yet", 64'(rdenA), 64'd0);
    @(negedge CLK);
    chk("t3_rden", 64'(rdenA), 64'd1);
    chk("t3_rdaddr", 64'(rdaddrsA), 64'd9);
    @(negedge CLK);
    @(negedge CLK);
    chk("t3_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_out_data", 64'(bus.out_data), 64'h9ABCDEF0);
    chk("t3_out_flags", 64'(bus.out_flags), 64'b1001);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t3_slot9_freed", 64'(slot_valid), 64'h0008);

    // Test 4: slot 5 never written -> timeout after 255 WAIT cycles
    req(4'd5, 1'b1, 1'b1);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 254; i++) begin
      @(negedge CLK);
      if (bus.out_valid || rdenA) early++;
    end
    chk("t4_no_early_completion", 64'(early), 64'd0);
    @(negedge CLK);
    chk("t4_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_out_err", 64'(bus.out_err), 64'd1);
    chk("t4_out_data", 64'(bus.out_data), 64'd0);
    chk("t4_out_flags", 64'(bus.out_flags), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("t4_slot_unchanged", 64'(slot_valid), 64'h0008);
    chk("t4_out_done", 64'(bus.out_valid), 64'd0);

    // Test 5: backpressure in OUT; clear and set coincide on handshake
    req(4'd3, 1'b0, 1'b1);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t5_stall_valid", 64'(bus.out_valid), 64'd1);
      chk("t5_stall_data", 64'(bus.out_data), 64'hFFFFFFFE);
      chk("t5_stall_flags", 64'(bus.out_flags), 64'b0010);
      chk("t5_stall_req_ready", 64'(bus.req_ready), 64'd0);
      mul_wren = (i == 4);
      mul_wraddrs = 4'd3;
      @(negedge CLK);
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    mul_wren = 1'b1; mul_wraddrs = 4'd3;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    mul_wren = 1'b0;
    chk("t5_set_wins", 64'(slot_valid), 64'h0008);
    chk("t5_req_ready", 64'(bus.req_ready), 64'd1);

    // Test 6a: reset during READ
    req(4'd3, 1'b0, 1'b0);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    chk("t6_in_read", 64'(rdenA), 64'd1);
    RESET = 1'b0;
    #1;
    chk("t6a_rden_zero", 64'(rdenA), 64'd0);
    chk("t6a_rdaddr_zero", 64'(rdaddrsA), 64'd0);
    chk("t6a_slot_zero", 64'(slot_valid), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t6a_no_rden", 64'(rdenA), 64'd0);
      chk("t6a_no_out", 64'(bus.out_valid), 64'd0);
      chk("t6a_req_ready", 64'(bus.req_ready), 64'd1);
    end

    // Test 6b: reset during OUT
    mul_wren = 1'b1; mul_wraddrs = 4'd3;
    @(negedge CLK);
    mul_wren = 1'b0;
    req(4'd3, 1'b1, 1'b1);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("t6b_in_out", 64'(bus.out_valid), 64'd1);
    RESET = 1'b0;
    #1;
    chk("t6b_out_valid_zero", 64'(bus.out_valid), 64'd0);
    chk("t6b_out_data_zero", 64'(bus.out_data), 64'd0);
    chk("t6b_out_flags_zero", 64'(bus.out_flags), 64'd0);
    chk("t6b_slot_zero", 64'(slot_valid), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t6b_no_rden", 64'(rdenA), 64'd0);
      chk("t6b_no_out", 64'(bus.out_valid), 64'd0);
      chk("t6b_req_ready", 64'(bus.req_ready), 64'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mul_result_reader.md
Name: mul_result_reader

Overview:
- Downstream consumer of the integer multiplier's 16-entry result buffer.
- Tracks which result slots have been written and accepts read requests from the writeback/operand-fetch side.
- Issues the buffer's port-A read, then returns the selected 32-bit half of the 64-bit product plus the {C,V,N,Z} flags over a valid/ready handshake.
- Stalls requests to slots not yet written, with a bounded timeout.

Parameters:
- ADDRS_WIDTH, 4: slot address width (includes thread#); 2**ADDRS_WIDTH slots.
- WAIT_LIMIT, 255: maximum cycles spent in WAIT before an error completion; range 1..255.
- WCNT_WIDTH, 8: wait-counter width; must hold WAIT_LIMIT.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- mul_wren  in  1  mirror of the multiplier's buffer write enable.
- mul_wraddrs  in  ADDRS_WIDTH  mirror of the multiplier's buffer write address.
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addrs  in  ADDRS_WIDTH  slot to read.
- req_hi  in  1  1 = product[63:32], 0 = product[31:0].
- req_last  in  1  1 = free the slot when the response is accepted.
- rdenA  out  1  buffer port-A read enable.
- rdaddrsA  out  ADDRS_WIDTH  buffer port-A read address.
- rddataA  in  68  buffer read data: {C,V,N,Z,product[63:0]}, valid the cycle after rdenA.
- out_valid  out  1  response valid.
- out_ready  in  1  response accepted when out_valid && out_ready.
- out_data  out  32  selected product half.
- out_flags  out  4  {C,V,N,Z}, taken from rddataA[67:64].
- out_err  out  1  1 = timeout completion; out_data and out_flags are 0.
- slot_valid  out  2**ADDRS_WIDTH  written-and-not-freed bitmap.

Behaviour:
- Reset (RESET low, asynchronous): state IDLE; slot_valid=0; wait counter=0; outputs forced as follows:
  - req_ready=1
  - rdenA=0, rdaddrsA=0
  - out_valid=0, out_data=0, out_flags=0, out_err=0
- Reset asserted mid-operation discards any in-flight request and response. rdenA must not glitch high.
- Bitmap update, every cycle:
  - mul_wren sets slot_valid[mul_wraddrs].
  - A response accepted with latched last=1 clears slot_valid[latched addr].
  - A set and a clear of the same slot in the same cycle: set wins.
- Registered outputs: all FSM outputs, rdenA and rdaddrsA. req_ready = (state==IDLE).
- IDLE:
  - On request handshake, latch addr, hi and last.
  - If slot_valid[req_addrs]==1 at that edge, go to READ; otherwise go to WAIT with counter=0.
  - A write to the same slot in the same cycle as the request does not count; the request goes to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If slot_valid[addr]==1, go to READ.
  - Else if counter==WAIT_LIMIT-1, go to OUT with out_err=1, out_data=0, out_flags=0.
- READ (exactly one cycle): rdenA=1, rdaddrsA=latched addr; next state CAPT.
- CAPT (exactly one cycle): register rddataA, then go to OUT.
  - out_data = hi ? rddataA[63:32] : rddataA[31:0].
  - out_flags = rddataA[67:64]; out_err=0.
- OUT:
  - out_valid=1; out_data, out_flags and out_err held stable until out_ready.
  - On handshake: clear the slot if last && !out_err, then go to IDLE.
  - A timeout completion never clears a slot.
- Latency, request accepted at edge T with slot valid:
  - rdenA high in cycle T+1.
  - out_valid high from cycle T+3.
  - Earliest next request acceptance is the edge after the out handshake, so one request is in flight at a time.
- rdenA is never asserted outside READ. rdaddrsA holds its last value when rdenA=0.
- A wren to the slot currently in CAPT or OUT does not alter the captured response.

Test Plan:
- Reset, then mul_wren to slot 3. Request slot 3, hi=0, last=1. Bench RAM returns rddataA={4'b0010, 64'hFFFFFFFF_FFFFFFFE} -> rdenA=1, rdaddrsA=3 one cycle after acceptance; out_data=32'hFFFFFFFE, out_flags=4'b0010 two cycles later; slot_valid[3]=0 after handshake.
- Same slot 3 content, request hi=1, last=0 -> out_data=32'hFFFFFFFF; slot_valid[3] remains 1.
- Request slot 9 while unwritten; mul_wren to slot 9 five cycles later -> remains in WAIT; rdenA asserted the cycle after slot_valid[9] rises; normal response follows.
- Request slot 5, never written, WAIT_LIMIT=255 -> out_valid with out_err=1, out_data=0, out_flags=0 after 255 WAIT cycles; slot_valid unchanged.
- Hold out_ready=0 for 10 cycles in OUT, pulse mul_wren to the same slot meanwhile -> out_* stable; req_ready=0. With last=1, the clear coincides with a new wren on the handshake cycle -> slot_valid stays 1.
- Assert RESET low during READ and during OUT -> all outputs zero immediately; slot_valid=0; req_ready=1 after release; no rdenA pulse.
